uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, default bit timing
// and the 2-of-3 vote used by the optional majority sampler.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 2813;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Flop-chain synchronizer for an asynchronous input pin; resets to the idle-high level
// so a reset never looks like a falling edge downstream.
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    // shift the pin through the chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register, framing-error pulse and sticky overrun.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote around each mid-bit, decided one clock later.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    input  logic                      read,
    output logic [UART_DATA_BITS-1:0] data_rx,
    output logic                      data_valid,
    output logic                      frame_error,
    output logic                      overrun,
    output logic                      busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC_OFS = 1;
`else
    localparam int DEC_OFS = 0;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] START_DEC = CNT_W'(CLKS_PER_BIT / 2 + DEC_OFS);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    logic                      w_rxs;
    uart_rx_state_t            r_state;
    uart_rx_state_t            w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [BIT_W-1:0]          r_bit;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic [CNT_W-1:0]          w_dec_cnt;
    logic                      w_tick;
    logic                      w_sample;
    logic                      w_shift;
    logic                      w_complete;
    logic                      w_ferr;
    logic [UART_DATA_BITS-1:0] r_data_rx;
    logic                      r_data_valid;
    logic                      r_frame_error;
    logic                      r_overrun;
    logic                      r_busy;

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rxs)
    );

    // START decides at half a bit; DATA/STOP decide on the last count, which lands at mid-bit
    always_comb begin
        w_dec_cnt = CNT_LAST;
        case (r_state)
            START:   w_dec_cnt = START_DEC;
            default: w_dec_cnt = CNT_LAST;
        endcase
        w_tick = (r_cnt == w_dec_cnt);
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_vote;

    // capture the two samples preceding each decision point
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vote <= 2'b11;
        end else if (r_cnt == (w_dec_cnt - CNT_W'(2))) begin
            r_vote[1] <= w_rxs;
        end else if (r_cnt == (w_dec_cnt - CNT_W'(1))) begin
            r_vote[0] <= w_rxs;
        end else begin
            r_vote <= r_vote;
        end
    end

    assign w_sample = maj3(r_vote[1], r_vote[0], w_rxs);
`else
    assign w_sample = w_rxs;
`endif

    // next-state and per-cycle decision strobes
    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_complete  = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxs) w_state_nxt = START;
                else        w_state_nxt = IDLE;
            end
            START: begin
                if (w_tick) w_state_nxt = w_sample ? IDLE : DATA;
                else        w_state_nxt = START;
            end
            DATA: begin
                w_shift = w_tick;
                if (w_tick && (r_bit == BIT_LAST)) w_state_nxt = STOP;
                else                               w_state_nxt = DATA;
            end
            STOP: begin
                w_complete = w_tick & w_sample;
                w_ferr     = w_tick & ~w_sample;
                if (w_tick) w_state_nxt = w_sample ? IDLE : WAIT_HIGH;
                else        w_state_nxt = STOP;
            end
            WAIT_HIGH: begin
                if (w_rxs) w_state_nxt = IDLE;
                else       w_state_nxt = WAIT_HIGH;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // baud counter: restarts on every state change, wraps once per bit period
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == IDLE) || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit   <= '0;
            r_shreg <= '0;
        end else begin
            if (w_state_nxt != r_state) r_bit <= '0;
            else if (w_shift)           r_bit <= r_bit + BIT_W'(1);
            else                        r_bit <= r_bit;
            if (w_shift) r_shreg <= {w_sample, r_shreg[UART_DATA_BITS-1:1]};
            else         r_shreg <= r_shreg;
        end
    end

    // holding register handshake; a read coinciding with completion makes room for the new byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_rx     <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_error <= w_ferr;
            r_busy        <= (w_state_nxt != IDLE);
            if (w_complete) begin
                if (!r_data_valid || read) begin
                    r_data_rx    <= r_shreg;
                    r_data_valid <= 1'b1;
                    if (read) r_overrun <= 1'b0;
                    else      r_overrun <= r_overrun;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (read && r_data_valid) begin
                r_data_valid <= 1'b0;
                r_overrun    <= 1'b0;
            end else begin
                r_data_valid <= r_data_valid;
            end
        end
    end

    assign data_rx     = r_data_rx;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, an event-queue model of when each frame must land,
// and a negedge compare of every output on every cycle.
module tb_uart_rx;

    localparam int C = 16;
    localparam int S = 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // start-edge to delivery: sync + IDLE detect, half bit to the start decision, nine more bits
    localparam int LAT = S + 2 + C / 2 + 9 * C + MAJ;

    localparam int EV_ON   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_FERR = 2;
    localparam int EV_OFF  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       read = 1'b0;
    logic [7:0] data_rx;
    logic       data_valid;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .read        (read),
        .data_rx     (data_rx),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] b;
    } ev_t;

    ev_t        evq[$];
    ev_t        keep[$];
    int         cyc = 0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_db;
    bit         m_valid = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_ferr = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_done;
    bit         cmp_en = 1'b0;
    int         nvec = 0;
    int         nfail = 0;
    int         ferr_seen = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %02h, want %02h", name, cyc, act, exp);
        end
    endtask

    // model: holding-register rules applied at each clock, frame outcomes taken from the event queue
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            evq.delete();
            m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_busy = 1'b0;
        end else begin
            m_done = 1'b0;
            m_ferr = 1'b0;
            m_db   = 8'h00;
            keep.delete();
            foreach (evq[i]) begin
                if (evq[i].cyc != cyc)           keep.push_back(evq[i]);
                else if (evq[i].kind == EV_ON)   m_busy = 1'b1;
                else if (evq[i].kind == EV_OFF)  m_busy = 1'b0;
                else if (evq[i].kind == EV_FERR) m_ferr = 1'b1;
                else begin
                    m_done = 1'b1; m_db = evq[i].b; m_busy = 1'b0;
                end
            end
            evq = keep;
            if (m_done) begin
                if (!m_valid || read) begin
                    m_data  = m_db;
                    m_valid = 1'b1;
                    if (read) m_ovr = 1'b0;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (read && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
        end
    end

    // compare every output against the model away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("data_rx", data_rx, m_data);
            chk("data_valid", {7'd0, data_valid}, {7'd0, m_valid});
            chk("frame_error", {7'd0, frame_error}, {7'd0, m_ferr});
            chk("overrun", {7'd0, overrun}, {7'd0, m_ovr});
            chk("busy", {7'd0, busy}, {7'd0, m_busy});
            if (frame_error === 1'b1) ferr_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input int kind, input logic [7:0] b);
        ev_t e;
        e.cyc = c; e.kind = kind; e.b = b;
        evq.push_back(e);
    endtask

    task automatic pulse_read();
        read = 1'b1;
        tick(1);
        read = 1'b0;
    endtask

    // one 8N1 frame; optional mid-bit spikes, read at the delivery clock, or reset inside a data bit
    task automatic send(input logic [7:0] b, input logic [7:0] expb, input bit stop,
                        input bit spike, input bit rd, input int rst_bit);
        int k0;
        k0 = cyc;
        push(k0 + S + 1, EV_ON, 8'h00);
        push(k0 + LAT, stop ? EV_DONE : EV_FERR, expb);
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (spike) begin
                tick(C / 2 + 1); rx = ~b[i]; tick(1); rx = b[i]; tick(C - C / 2 - 2);
            end else if (i == rst_bit) begin
                tick(4); rst = 1'b1; tick(3); rst = 1'b0; tick(C - 7);
            end else begin
                tick(C);
            end
        end
        rx = stop;
        if (rd) begin
            tick(LAT - 9 * C - 1); read = 1'b1; tick(1); read = 1'b0; tick(C - (LAT - 9 * C));
        end else begin
            tick(C);
        end
    endtask

    logic [7:0] spike_exp;
    int         h;

    initial begin
        tick(3);
        cmp_en = 1'b1;
        tick(2);
        chk("rst_data_rx", data_rx, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        rst = 1'b0;
        tick(2 * C);

        // plain byte, then read it out
        send(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, -1);
        tick(C);
        chk("a5_data", data_rx, 8'hA5);
        chk("a5_valid", {7'd0, data_valid}, 8'h01);
        pulse_read();
        chk("a5_read_clears", {7'd0, data_valid}, 8'h00);
        pulse_read();
        tick(C);

        // back-to-back overrun, then read landing on the completion clock of a third frame
        send(8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0, -1);
        send(8'hC3, 8'hC3, 1'b1, 1'b0, 1'b0, -1);
        tick(C);
        chk("ovr_data_kept", data_rx, 8'h3C);
        chk("ovr_flag", {7'd0, overrun}, 8'h01);
        send(8'h55, 8'h55, 1'b1, 1'b0, 1'b1, -1);
        chk("rd_at_done_data", data_rx, 8'h55);
        chk("rd_at_done_valid", {7'd0, data_valid}, 8'h01);
        chk("rd_at_done_ovr", {7'd0, overrun}, 8'h00);
        pulse_read();
        tick(C);

        // framing error followed by a 40-bit break, then recovery
        ferr_seen = 0;
        send(8'h81, 8'h81, 1'b0, 1'b0, 1'b0, -1);
        tick(40 * C);
        chk("break_busy", {7'd0, busy}, 8'h01);
        chk("ferr_no_load", {7'd0, data_valid}, 8'h00);
        chk("ferr_one_pulse", 8'(ferr_seen), 8'h01);
        h = cyc;
        rx = 1'b1;
        push(h + S + 1, EV_OFF, 8'h00);
        tick(2 * C);
        send(8'h7E, 8'h7E, 1'b1, 1'b0, 1'b0, -1);
        tick(C);
        chk("after_break_data", data_rx, 8'h7E);
        pulse_read();
        tick(C);

        // three-clock glitch on an idle line
        h = cyc;
        push(h + S + 1, EV_ON, 8'h00);
        push(h + S + 1 + C / 2 + 1 + MAJ, EV_OFF, 8'h00);
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(2 * C);
        chk("glitch_valid", {7'd0, data_valid}, 8'h00);
        chk("glitch_busy", {7'd0, busy}, 8'h00);

        // reset inside bit 4 of 0xFF, then a clean 0x12
        send(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 4);
        tick(C);
        chk("rst_abort_valid", {7'd0, data_valid}, 8'h00);
        send(8'h12, 8'h12, 1'b1, 1'b0, 1'b0, -1);
        tick(C);
        chk("post_rst_data", data_rx, 8'h12);
        pulse_read();
        tick(C);

        // one-clock inverted spike at every data mid-bit
        spike_exp = (MAJ != 0) ? 8'h96 : 8'h69;
        send(8'h96, spike_exp, 1'b1, 1'b1, 1'b0, -1);
        tick(C);
        chk("spike_data", data_rx, spike_exp);
        pulse_read();
        tick(C);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
